btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the number of independent button channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), giving the stable-input time in clocks; the legal range is DEBOUNCE_CYCLES >= 1.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single system clock, all logic on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port BTN, input, WIDTH bits: raw, asynchronous, bouncing buttons, 1 = pressed.
REQ-006 The block SHALL have port BTN_LEVEL, output, WIDTH bits: the debounced button state.
REQ-007 The block SHALL have port BTN_PRESS, output, WIDTH bits: a one-cycle pulse on each debounced 0->1 transition.
REQ-008 The block SHALL have port BTN_RELEASE, output, WIDTH bits: a one-cycle pulse on each debounced 1->0 transition.
REQ-009 The block SHALL have port BTN_TOGGLE, output, WIDTH bits: a state bit that flips on every debounced press.

Function
REQ-010 Each channel SHALL pass BTN[i] through a two-flop synchronizer before any other use; no logic SHALL read BTN directly.
REQ-011 Each channel SHALL hold a stable register (drives BTN_LEVEL[i]) and a counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-012 The counter SHALL clear on any cycle where the synchronized input equals the stable register.
REQ-013 The counter SHALL increment by 1 on any cycle where the synchronized input differs from the stable register.
REQ-014 On the edge where the counter would reach DEBOUNCE_CYCLES, the stable register SHALL take the synchronized value and the counter SHALL clear; the counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL not wrap.
REQ-015 Latency from a clean BTN change meeting setup to BTN_LEVEL change SHALL be exactly 2 + DEBOUNCE_CYCLES clock edges.
REQ-016 A difference lasting fewer than DEBOUNCE_CYCLES consecutive synchronized cycles (a glitch or bounce) SHALL produce no output change, and the counter SHALL restart from 0 on the next difference.
REQ-017 BTN_PRESS[i] SHALL be registered and high for exactly the one cycle in which BTN_LEVEL[i] first reads 1 after a 0.
REQ-018 BTN_RELEASE[i] SHALL behave the same way as BTN_PRESS[i], for a change of BTN_LEVEL[i] from 1 to 0.
REQ-019 BTN_PRESS[i] and BTN_RELEASE[i] SHALL never be high in the same cycle.
REQ-020 BTN_TOGGLE[i] SHALL invert in the same cycle that BTN_PRESS[i] is high, and SHALL not change on release.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-022 While RESET is high at a CLK edge, the synchronizer flops, stable registers, counters, BTN_LEVEL, BTN_PRESS, BTN_RELEASE and BTN_TOGGLE SHALL all become 0.
REQ-023 Reset asserted mid-count SHALL discard the partial count, and no pulse SHALL be emitted for it.
REQ-024 A button held through reset release SHALL be treated as a new press: BTN_PRESS pulses 2 + DEBOUNCE_CYCLES edges after RESET deasserts.

Structure
REQ-025 No shared package is needed; DEBOUNCE_CYCLES and the counter width SHALL be module parameters or local parameters only.
REQ-026 The per-channel logic SHALL be one sub-module, btn_debounce_bit (synchronizer, counter, stable register, pulse and toggle), instantiated WIDTH times by a generate loop.

Verification (DEBOUNCE_CYCLES=4, WIDTH=2)
REQ-027 Clean press: BTN=01 held from cycle 0 -> BTN_LEVEL=01 and BTN_PRESS=01 for exactly one cycle at edge 6, and BTN_TOGGLE=01.
REQ-028 Bounce: BTN[0] toggles 1,0,1,0 every cycle, then holds at 1 -> exactly one press pulse, 6 edges after the final rising edge.
REQ-029 Release and second press: after a press, BTN=00 -> BTN_RELEASE=01 one cycle with BTN_TOGGLE unchanged; pressing again -> BTN_TOGGLE returns to 00.
REQ-030 Glitch: BTN[1] high for 3 cycles only -> BTN_LEVEL, BTN_PRESS and BTN_RELEASE stay 00 throughout.
REQ-031 Simultaneous: BTN 00->11 on the same edge -> BTN_PRESS=11 in a single cycle.
REQ-032 Reset mid-count: RESET pulsed at count 2 while BTN=01 held -> all outputs 0, then a press pulse 6 edges after RESET deasserts.

Source files
------------

// File: rtl/btn_debounce_bit.sv
// One debounced button channel: two-flop synchronizer, stability counter,
// debounced level, one-cycle press/release pulses and a press-toggled bit.
module btn_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic toggle
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_q;
    logic [CNT_W-1:0] cnt;

    // NOTE: every register here uses <= so each flop samples the values from
    // before the edge; blocking writes would collapse the synchronizer stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta     <= 1'b0;
            sync_q        <= 1'b0;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            toggle        <= 1'b0;
        end else begin
            sync_meta     <= btn;
            sync_q        <= sync_meta;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;

            if (sync_q == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Difference has held for DEBOUNCE_CYCLES cycles: accept it.
                level         <= sync_q;
                cnt           <= '0;
                press_pulse   <= sync_q;
                release_pulse <= ~sync_q;
                if (sync_q) begin
                    toggle <= ~toggle;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer: WIDTH independent copies of btn_debounce_bit
// sharing one clock and synchronous reset.
module btn_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] BTN,
    output logic [WIDTH-1:0] BTN_LEVEL,
    output logic [WIDTH-1:0] BTN_PRESS,
    output logic [WIDTH-1:0] BTN_RELEASE,
    output logic [WIDTH-1:0] BTN_TOGGLE
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        btn_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk          (CLK),
            .reset        (RESET),
            .btn          (BTN[i]),
            .level        (BTN_LEVEL[i]),
            .press_pulse  (BTN_PRESS[i]),
            .release_pulse(BTN_RELEASE[i]),
            .toggle       (BTN_TOGGLE[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with WIDTH=2, DEBOUNCE_CYCLES=4: a settled
// input change shows on BTN_LEVEL at the 6th rising edge after it is applied.
module tb_btn_debounce;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [1:0] BTN;
    logic [1:0] BTN_LEVEL;
    logic [1:0] BTN_PRESS;
    logic [1:0] BTN_RELEASE;
    logic [1:0] BTN_TOGGLE;

    int checks   = 0;
    int failures = 0;

    btn_debounce #(
        .WIDTH          (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .BTN        (BTN),
        .BTN_LEVEL  (BTN_LEVEL),
        .BTN_PRESS  (BTN_PRESS),
        .BTN_RELEASE(BTN_RELEASE),
        .BTN_TOGGLE (BTN_TOGGLE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1;
        BTN   = 2'b00;
        step();
        step();
        check("reset_level", BTN_LEVEL, 2'b00);
        check("reset_press", BTN_PRESS, 2'b00);
        check("reset_release", BTN_RELEASE, 2'b00);
        check("reset_toggle", BTN_TOGGLE, 2'b00);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("idle_level", BTN_LEVEL, 2'b00);

        // Clean press on channel 0.
        BTN = 2'b01;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("press_wait_level", BTN_LEVEL, 2'b00);
            check("press_wait_pulse", BTN_PRESS, 2'b00);
        end
        step();
        check("press_level", BTN_LEVEL, 2'b01);
        check("press_pulse", BTN_PRESS, 2'b01);
        check("press_toggle", BTN_TOGGLE, 2'b01);
        check("press_no_release", BTN_RELEASE, 2'b00);
        step();
        check("press_pulse_end", BTN_PRESS, 2'b00);
        check("press_level_hold", BTN_LEVEL, 2'b01);

        // Release: pulse on BTN_RELEASE, toggle untouched.
        BTN = 2'b00;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("rel_wait_level", BTN_LEVEL, 2'b01);
        end
        step();
        check("rel_level", BTN_LEVEL, 2'b00);
        check("rel_pulse", BTN_RELEASE, 2'b01);
        check("rel_no_press", BTN_PRESS, 2'b00);
        check("rel_toggle", BTN_TOGGLE, 2'b01);
        step();
        check("rel_pulse_end", BTN_RELEASE, 2'b00);

        // Second press flips toggle back.
        BTN = 2'b01;
        for (int i = 0; i < 6; i++) step();
        check("press2_pulse", BTN_PRESS, 2'b01);
        check("press2_toggle", BTN_TOGGLE, 2'b00);
        BTN = 2'b00;
        for (int i = 0; i < 8; i++) step();
        check("press2_released", BTN_LEVEL, 2'b00);
        check("press2_toggle_hold", BTN_TOGGLE, 2'b00);

        // Glitch: channel 1 high for only 3 cycles.
        BTN = 2'b10;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) BTN = 2'b00;
            step();
            check("glitch_level", BTN_LEVEL, 2'b00);
            check("glitch_press", BTN_PRESS, 2'b00);
            check("glitch_release", BTN_RELEASE, 2'b00);
        end

        // Bounce 1,0,1,0 then hold 1: one press, 6 edges after the final rise.
        BTN = 2'b01; step(); check("bounce_press", BTN_PRESS, 2'b00);
        BTN = 2'b00; step(); check("bounce_press", BTN_PRESS, 2'b00);
        BTN = 2'b01; step(); check("bounce_press", BTN_PRESS, 2'b00);
        BTN = 2'b00; step(); check("bounce_press", BTN_PRESS, 2'b00);
        BTN = 2'b01;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("bounce_wait_press", BTN_PRESS, 2'b00);
            check("bounce_wait_level", BTN_LEVEL, 2'b00);
        end
        step();
        check("bounce_pulse", BTN_PRESS, 2'b01);
        check("bounce_level", BTN_LEVEL, 2'b01);
        for (int i = 0; i < 8; i++) begin
            step();
            check("bounce_single", BTN_PRESS, 2'b00);
        end
        BTN = 2'b00;
        for (int i = 0; i < 8; i++) step();
        check("bounce_released", BTN_LEVEL, 2'b00);

        // Simultaneous press and release on both channels.
        BTN = 2'b11;
        for (int i = 1; i <= 5; i++) step();
        check("simul_wait", BTN_PRESS, 2'b00);
        step();
        check("simul_press", BTN_PRESS, 2'b11);
        check("simul_level", BTN_LEVEL, 2'b11);
        step();
        check("simul_press_end", BTN_PRESS, 2'b00);
        BTN = 2'b00;
        for (int i = 1; i <= 5; i++) step();
        check("simul_rel_wait", BTN_RELEASE, 2'b00);
        step();
        check("simul_release", BTN_RELEASE, 2'b11);
        check("simul_rel_level", BTN_LEVEL, 2'b00);
        for (int i = 0; i < 4; i++) step();

        // Reset at count 2 with BTN[0] held, then treated as a fresh press.
        BTN = 2'b01;
        for (int i = 0; i < 4; i++) step();
        RESET = 1'b1;
        step();
        check("midrst_level", BTN_LEVEL, 2'b00);
        check("midrst_press", BTN_PRESS, 2'b00);
        check("midrst_release", BTN_RELEASE, 2'b00);
        check("midrst_toggle", BTN_TOGGLE, 2'b00);
        RESET = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("midrst_wait_press", BTN_PRESS, 2'b00);
            check("midrst_wait_level", BTN_LEVEL, 2'b00);
        end
        step();
        check("midrst_pulse", BTN_PRESS, 2'b01);
        check("midrst_level_up", BTN_LEVEL, 2'b01);
        check("midrst_toggle_up", BTN_TOGGLE, 2'b01);
        step();
        check("midrst_pulse_end", BTN_PRESS, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
